prog_lut_n: RTL and testbench

- Parametrised, run-time reprogrammable N-input Boolean function block.
- Successor to the fixed 3-input truth-table gates in the circuit library.
- Evaluates an N-bit input vector through a registered 2-stage pipeline.
- The truth table can be reloaded serially over a valid/ready config port; the new table is swapped in atomically, so the active function never holds a partially loaded table.

---
 rtl/prog_lut_pkg.sv | 10 +
 rtl/prog_lut_cfg_shift.sv | 68 ++++++
 rtl/prog_lut_n.sv | 62 ++++++
 tb/tb_prog_lut_n.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/prog_lut_pkg.sv
// Shared types and helpers for the programmable N-input LUT.
package prog_lut_pkg;
  localparam int MAX_N_IN = 6;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} cfg_state_e;

  function automatic int tt_w(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/prog_lut_cfg_shift.sv
// Serial truth-table loader: shadow shift register, bit counter and the
// IDLE/SHIFT/COMMIT handshake FSM. commit is high for the single swap cycle.
module prog_lut_cfg_shift import prog_lut_pkg::*; #(
  parameter int N_IN = 3,
  localparam int TT_W = tt_w(N_IN)
)(
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  input  logic            cfg_abort,
  output logic            cfg_ready,
  output logic            commit,
  output logic [TT_W-1:0] shadow
);
  localparam int CW = $clog2(TT_W) + 1;
  localparam logic [CW-1:0] LAST = CW'(TT_W - 1);

  cfg_state_e    state, state_nx;
  logic [CW-1:0] count;
  logic          shift_en, clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Abort wins over a same-cycle handshake; COMMIT ignores both.
  always_comb begin
    state_nx  = state;
    cfg_ready = 1'b0;
    commit    = 1'b0;
    shift_en  = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE, SHIFT: begin
        cfg_ready = 1'b1;
        if (cfg_abort) begin
          clr      = 1'b1;
          state_nx = IDLE;
        end else if (cfg_valid) begin
          shift_en = 1'b1;
          state_nx = (count == LAST) ? COMMIT : SHIFT;
        end
      end
      COMMIT: begin
        commit   = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow <= '0;
      count  <= '0;
    end else if (clr) begin
      shadow <= '0;
      count  <= '0;
    end else if (shift_en) begin
      shadow <= {shadow[TT_W-2:0], cfg_bit};
      count  <= count + 1'b1;
    end else if (commit) begin
      count  <= '0;
    end
  end
endmodule

// File: rtl/prog_lut_n.sv
// Run-time reprogrammable N-input Boolean function with a 2-stage eval
// pipeline and an atomically swapped truth table.
module prog_lut_n import prog_lut_pkg::*; #(
  parameter int                    N_IN     = 3,
  parameter logic [tt_w(N_IN)-1:0] RESET_TT = 'h91
)(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_IN-1:0]       in_vec,
  input  logic                  in_valid,
  output logic                  out,
  output logic                  out_valid,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic                  cfg_bit,
  input  logic                  cfg_abort,
  output logic                  cfg_done,
  output logic [tt_w(N_IN)-1:0] tt_active
);
  localparam int TT_W   = tt_w(N_IN);
  localparam int STAGES = 2;

  logic [TT_W-1:0]   shadow;
  logic              commit;
  logic [N_IN-1:0]   idx_s1, rev_idx;
  logic [STAGES:1]   vld_pipe;

  prog_lut_cfg_shift #(.N_IN(N_IN)) u_cfg (
    .clk       (clk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_bit   (cfg_bit),
    .cfg_abort (cfg_abort),
    .cfg_ready (cfg_ready),
    .commit    (commit),
    .shadow    (shadow)
  );

  assign cfg_done = commit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         tt_active <= RESET_TT;
    else if (commit) tt_active <= shadow;
  end

  // Table is stored MSB-first, so entry idx lives at bit TT_W-1-idx == ~idx.
  assign rev_idx = ~idx_s1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      idx_s1   <= '0;
      out      <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
      idx_s1   <= in_vec;
      if (vld_pipe[1]) out <= tt_active[rev_idx];
    end
  end

  assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_prog_lut_n.sv
// Directed self-checking bench for prog_lut_n (N_IN=3 default and N_IN=4).
module tb_prog_lut_n;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0] in_vec;
  logic       in_valid, out, out_valid;
  logic       cfg_valid, cfg_ready, cfg_bit, cfg_abort, cfg_done;
  logic [7:0] tt_active;

  logic [3:0]  in_vec_b;
  logic        in_valid_b, out_b, out_valid_b, cfg_ready_b, cfg_done_b;
  logic        cfg_valid_b, cfg_bit_b, cfg_abort_b;
  logic [15:0] tt_active_b;

  prog_lut_n dut (
    .clk(clk), .rst(rst), .in_vec(in_vec), .in_valid(in_valid),
    .out(out), .out_valid(out_valid), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .cfg_bit(cfg_bit), .cfg_abort(cfg_abort),
    .cfg_done(cfg_done), .tt_active(tt_active)
  );

  prog_lut_n #(.N_IN(4), .RESET_TT(16'h8001)) dut_b (
    .clk(clk), .rst(rst), .in_vec(in_vec_b), .in_valid(in_valid_b),
    .out(out_b), .out_valid(out_valid_b), .cfg_valid(cfg_valid_b),
    .cfg_ready(cfg_ready_b), .cfg_bit(cfg_bit_b), .cfg_abort(cfg_abort_b),
    .cfg_done(cfg_done_b), .tt_active(tt_active_b)
  );

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [7:0] tt_exp;

  always @(negedge clk) if (cfg_done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // exp[7-i] is the required result for in_vec = i.
  task automatic sweep(input string tag, input logic [7:0] exp);
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 8);
      in_vec   = c[2:0];
      if (c == 1) chk({tag, "_lat"}, out_valid, 0);
      if (c >= 2) begin
        chk({tag, "_vld"}, out_valid, 1);
        chk($sformatf("%s_out%0d", tag, c - 2), out, exp[9-c]);
      end
      tick();
    end
    in_valid = 1'b0;
    chk({tag, "_vld_end"}, out_valid, 0);
    chk({tag, "_hold"}, out, exp[0]);
  endtask

  task automatic load(input string tag, input logic [7:0] val, input bit gapped);
    int d0;
    d0 = done_cnt;
    for (int i = 7; i >= 0; i--) begin
      if (gapped) begin
        cfg_valid = 1'b0;
        tick();
        chk({tag, "_gap_rdy"}, cfg_ready, 1);
        chk({tag, "_gap_done"}, cfg_done, 0);
      end
      cfg_valid = 1'b1;
      cfg_bit   = val[i];
      chk({tag, "_rdy"}, cfg_ready, 1);
      chk({tag, "_nodone"}, cfg_done, 0);
      chk({tag, "_tt_hold"}, tt_active, tt_exp);
      tick();
    end
    cfg_valid = 1'b0;
    chk({tag, "_commit_rdy"}, cfg_ready, 0);
    chk({tag, "_done"}, cfg_done, 1);
    chk({tag, "_tt_old"}, tt_active, tt_exp);
    tick();
    tt_exp = val;
    chk({tag, "_tt_new"}, tt_active, val);
    chk({tag, "_rdy_back"}, cfg_ready, 1);
    chk({tag, "_pulses"}, done_cnt - d0, 1);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    in_vec = '0; in_valid = 1'b0;
    cfg_valid = 1'b0; cfg_bit = 1'b0; cfg_abort = 1'b0;
    in_vec_b = '0; in_valid_b = 1'b0;
    cfg_valid_b = 1'b0; cfg_bit_b = 1'b0; cfg_abort_b = 1'b0;
    tt_exp = 8'h91;
    #3;
    chk("rst_out", out, 0);
    chk("rst_vld", out_valid, 0);
    chk("rst_done", cfg_done, 0);
    chk("rst_rdy", cfg_ready, 1);
    chk("rst_tt", tt_active, 8'h91);
    chk("rst_tt_b", tt_active_b, 16'h8001);
    tick();
    rst = 1'b0;
    tick();

    // idx 0..7 -> 1,0,0,1,0,0,0,1
    sweep("rst_sweep", 8'b1001_0001);

    // N_IN=4: only in_vec 0 and 15 give 1.
    for (int c = 0; c < 18; c++) begin
      in_valid_b = (c < 16);
      in_vec_b   = c[3:0];
      if (c >= 2) begin
        chk("b_vld", out_valid_b, 1);
        chk($sformatf("b_out%0d", c - 2), out_b, ((c - 2) == 0 || (c - 2) == 15) ? 1 : 0);
      end
      tick();
    end
    in_valid_b = 1'b0;

    // Abort after 5 bits, with cfg_valid still high on the abort cycle.
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'b0;
      tick();
    end
    cfg_abort = 1'b1;
    chk("abort_rdy", cfg_ready, 1);
    tick();
    cfg_abort = 1'b0; cfg_valid = 1'b0;
    chk("abort_idle_rdy", cfg_ready, 1);
    chk("abort_tt", tt_active, 8'h91);
    repeat (3) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_tt_later", tt_active, 8'h91);

    // Full load after abort; MSB-first lookup of E8 gives 1,1,1,0,1,0,0,0.
    load("maj", 8'hE8, 1'b0);
    sweep("maj_sweep", 8'b1110_1000);

    load("gap", 8'h96, 1'b1);
    sweep("gap_sweep", 8'b1001_0110);

    // Swap boundary: in_vec=3 streamed while 8'h00 commits (COMMIT edge = edge 9).
    for (int c = 0; c < 14; c++) begin
      in_valid = 1'b1; in_vec = 3'd3;
      cfg_valid = (c < 8); cfg_bit = 1'b0;
      if (c == 8) chk("swap_done", cfg_done, 1);
      if (c >= 2) begin
        chk("swap_vld", out_valid, 1);
        chk($sformatf("swap_out%0d", c), out, (c <= 9) ? 1 : 0);
      end
      tick();
    end
    in_valid = 1'b0; cfg_valid = 1'b0;
    tt_exp = 8'h00;
    chk("swap_tt", tt_active, 8'h00);

    // Make out=1 observable, then reset asynchronously with count = 4.
    load("pre_rst", 8'h80, 1'b0);
    in_vec = 3'd0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cfg_valid = 1'b1; cfg_bit = 1'b1;
      tick();
    end
    cfg_valid = 1'b0;
    chk("mid_out_pre", out, 1);
    chk("mid_vld_pre", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_out_clr", out, 0);
    chk("mid_vld_clr", out_valid, 0);
    chk("mid_tt", tt_active, 8'h91);
    chk("mid_rdy", cfg_ready, 1);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    tick();
    tt_exp = 8'h91;
    chk("post_rst_tt", tt_active, 8'h91);
    chk("post_rst_rdy", cfg_ready, 1);
    sweep("post_rst_sweep", 8'b1001_0001);
    load("post_rst_load", 8'h3C, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
